// File: rtl/result_sram_arbiter_if.sv
// Result SRAM arbiter bus: macro/SFU handshakes and SRAM port.
// master = requesters/SRAM side, slave = arbiter side.
interface result_sram_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int ADDR_W  = 32
);
  logic [NUM_REQ-1:0] mac_req;
  logic [NUM_REQ-1:0] mac_gnt;
  logic               sfu_req;
  logic [ADDR_W-1:0]  sfu_addr;
  logic               sfu_gnt;
  logic               sfu_rdata_valid;
  logic [NUM_REQ:0]   rs_web;
  logic [ADDR_W-1:0]  rs_write_addr;
  logic [ADDR_W-1:0]  rs_sfu_read_addr;

  modport slave (
    input  mac_req,
    input  sfu_req,
    input  sfu_addr,
    output mac_gnt,
    output sfu_gnt,
    output sfu_rdata_valid,
    output rs_web,
    output rs_write_addr,
    output rs_sfu_read_addr
  );

  modport master (
    output mac_req,
    output sfu_req,
    output sfu_addr,
    input  mac_gnt,
    input  sfu_gnt,
    input  sfu_rdata_valid,
    input  rs_web,
    input  rs_write_addr,
    input  rs_sfu_read_addr
  );
endinterface

// File: rtl/result_sram_arbiter.sv
// Round-robin arbiter for the shared result SRAM port (macros + SFU).
// Optional SFU_PRIORITY_EN: SFU beats all macros, rr covers macros only.
module result_sram_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int ADDR_W   = 32,
  parameter int RMC_W    = 16,
  parameter int READ_LAT = 1
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic [RMC_W-1:0]   rmc_of_each_macro,
  input  logic               clr_stats,
  output logic [31:0]        num_of_wm,
  output logic [31:0]        result_memory_usage,
  output logic               busy,
  result_sram_arbiter_if.slave bus
);

  localparam int NS = NUM_REQ + 1;
`ifdef SFU_PRIORITY_EN
  localparam int   NRR = NUM_REQ;
  localparam logic PRI = 1'b1;
`else
  localparam int   NRR = NS;
  localparam logic PRI = 1'b0;
`endif
  localparam int PW = $clog2(NS);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [PW-1:0] L_LAST = PW'(NRR - 1);
  localparam logic [PW:0]   L_NRR  = (PW+1)'(NRR);
  localparam logic [PW-1:0] L_SFU  = PW'(NUM_REQ);
  localparam logic [CW-1:0] L_CNT  = CW'(READ_LAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]         r_state;
  logic [PW-1:0]      r_rr;
  logic [IW-1:0]      r_idx;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_written;
  logic [31:0]        r_num;
  logic [31:0]        r_usage;
  logic [ADDR_W-1:0]  r_waddr;
  logic [ADDR_W-1:0]  r_raddr;

  logic [NS-1:0]      w_cand;
  logic [PW:0]        w_s;
  logic               w_found;
  logic [PW-1:0]      w_win;
  logic [PW-1:0]      w_rr_nxt;
  logic               w_sfu_pri;
  logic               w_go_read;
  logic               w_go_write;
  logic               w_any;
  logic               w_idle;
  logic               w_wr;
  logic               w_rd;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ADDR_W-1:0]  w_waddr;
  logic [31:0]        w_use;

  assign w_cand = {bus.sfu_req, bus.mac_req};

  // first requesting slot at or after r_rr, wrapping over NRR slots
  always_comb begin
    w_s     = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NRR; k++) begin
      w_s = {1'b0, r_rr} + (PW+1)'(k);
      if (w_s >= L_NRR)
        w_s = w_s - L_NRR;
      if (!w_found && w_cand[w_s[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_s[PW-1:0];
      end
    end
  end

  assign w_sfu_pri  = PRI & bus.sfu_req;
  assign w_go_read  = w_sfu_pri |
                      (w_found & (w_win == L_SFU));
  assign w_go_write = ~w_sfu_pri & w_found &
                      (w_win != L_SFU);
  assign w_any      = w_go_read | w_go_write;
  assign w_rr_nxt   = (w_win == L_LAST) ? '0
                                        : w_win + 1'b1;

  assign w_idle = (r_state == S_IDLE);
  assign w_wr   = (r_state == S_WRITE);
  assign w_rd   = (r_state == S_READ);

  assign w_gnt   = w_wr ? (NUM_REQ'(1'b1) << r_idx) : '0;
  assign w_waddr = ADDR_W'(r_idx) *
                   ADDR_W'(rmc_of_each_macro);
  assign w_use   = r_num * 32'(rmc_of_each_macro);

  assign bus.mac_gnt          = w_gnt;
  assign bus.sfu_gnt          = w_rd;
  assign bus.rs_web           = {w_rd, w_gnt};
  assign bus.rs_write_addr    = w_wr ? w_waddr : r_waddr;
  assign bus.rs_sfu_read_addr = w_rd ? bus.sfu_addr
                                     : r_raddr;
  assign bus.sfu_rdata_valid  = (r_state == S_WAIT) &&
                                (r_cnt == '0);

  assign num_of_wm           = r_num;
  assign result_memory_usage = r_usage;
  assign busy                = ~w_idle;

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_waddr <= '0;
      r_raddr <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          unique case (1'b1)
            w_go_read:  r_state <= S_READ;
            w_go_write: begin
              r_state <= S_WRITE;
              r_idx   <= w_win[IW-1:0];
            end
            default:    r_state <= S_IDLE;
          endcase
        end
        S_WRITE: begin
          r_state <= S_IDLE;
          r_waddr <= w_waddr;
        end
        S_READ: begin
          r_state <= S_WAIT;
          r_cnt   <= L_CNT;
          r_raddr <= bus.sfu_addr;
        end
        S_WAIT: begin
          if (r_cnt == '0)
            r_state <= S_IDLE;
          else
            r_cnt <= r_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
      // SFU grants leave the pointer alone in priority mode
      if (w_idle &&
          (w_go_write || (w_go_read && !PRI)))
        r_rr <= w_rr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTn || clr_stats) begin
      r_written <= '0;
      r_num     <= '0;
      r_usage   <= '0;
    end else begin
      if (w_wr && !r_written[r_idx]) begin
        r_written[r_idx] <= 1'b1;
        r_num            <= r_num + 32'd1;
      end
      if (w_idle && !w_any && (w_use > r_usage))
        r_usage <= w_use;
    end
  end

endmodule

// File: tb/tb_result_sram_arbiter.sv
// Directed self-checking bench for result_sram_arbiter.
// DUT built with READ_LAT=3; honours SFU_PRIORITY_EN.
module tb_result_sram_arbiter;

  localparam int NUM_REQ = 8;
  localparam int ADDR_W  = 32;

`ifdef SFU_PRIORITY_EN
  localparam bit PRI = 1'b1;
`else
  localparam bit PRI = 1'b0;
`endif

  logic        clk;
  logic        RSTn;
  logic [15:0] rmc;
  logic        clr;
  logic [31:0] num_wm;
  logic [31:0] usage;
  logic        busy;

  int n_cmp;
  int n_err;

  result_sram_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)
  ) bus ();

  result_sram_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W),
    .RMC_W(16), .READ_LAT(3)
  ) dut (
    .clk                 (clk),
    .RSTn                (RSTn),
    .rmc_of_each_macro   (rmc),
    .clr_stats           (clr),
    .num_of_wm           (num_wm),
    .result_memory_usage (usage),
    .busy                (busy),
    .bus                 (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output int kind);
    kind = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.mac_gnt != '0) begin
        kind = 1;
        return;
      end
      if (bus.sfu_gnt) begin
        kind = 2;
        return;
      end
    end
  endtask

  initial begin
    int kind;
    int exp_k[3];
    logic [7:0] seen;
    logic vflag;

    n_cmp = 0;
    n_err = 0;
    RSTn  = 1'b0;
    rmc   = 16'd512;
    clr   = 1'b0;
    bus.mac_req  = '0;
    bus.sfu_req  = 1'b0;
    bus.sfu_addr = 32'h1000;

    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_web", bus.rs_web, 0);
    chk("rst_waddr", bus.rs_write_addr, 0);
    chk("rst_raddr", bus.rs_sfu_read_addr, 0);
    chk("rst_valid", bus.sfu_rdata_valid, 0);
    chk("rst_num", num_wm, 0);
    chk("rst_usage", usage, 0);
    RSTn = 1'b1;

    // round robin over all macros
    bus.mac_req = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_gnt%0d", i),
          bus.mac_gnt, 64'(1) << i);
      chk($sformatf("rr_web%0d", i),
          bus.rs_web, 64'(1) << i);
      chk($sformatf("rr_addr%0d", i),
          bus.rs_write_addr, 64'(i * 512));
      tick();
      chk($sformatf("rr_idle%0d", i),
          bus.rs_web, 0);
      chk($sformatf("rr_hold%0d", i),
          bus.rs_write_addr, 64'(i * 512));
      chk($sformatf("rr_num%0d", i),
          num_wm, 64'(i + 1));
    end
    tick();
    chk("rr_wrap", bus.mac_gnt, 8'h01);
    chk("rr_use_pre", usage, 0);
    bus.mac_req = '0;
    tick();
    chk("rr_num_end", num_wm, 8);
    tick();
    chk("rr_usage", usage, 4096);

    // repeat write to macro 3
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr0_num", num_wm, 0);
    chk("clr0_use", usage, 0);
    bus.mac_req = 8'h08;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rep_web%0d", i),
          bus.rs_web, 9'h008);
      if (i == 2)
        bus.mac_req = '0;
      tick();
      chk($sformatf("rep_off%0d", i),
          bus.rs_web, 0);
    end
    chk("rep_num", num_wm, 1);
    tick();
    chk("rep_use", usage, 512);

    // SFU read with 3-cycle latency
    bus.sfu_req = 1'b1;
    tick();
    chk("rd_gnt", bus.sfu_gnt, 1);
    chk("rd_web", bus.rs_web, 9'h100);
    chk("rd_addr", bus.rs_sfu_read_addr, 32'h1000);
    bus.sfu_req = 1'b0;
    bus.mac_req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rd_v%0d", i),
          bus.sfu_rdata_valid, (i == 2));
      chk($sformatf("rd_ng%0d", i),
          bus.mac_gnt, 0);
      chk($sformatf("rd_wz%0d", i), bus.rs_web, 0);
      chk($sformatf("rd_busy%0d", i), busy, 1);
    end
    bus.mac_req = '0;
    tick();
    chk("rd_vend", bus.sfu_rdata_valid, 0);
    chk("rd_hold", bus.rs_sfu_read_addr, 32'h1000);

    // fairness / priority
    if (PRI) exp_k = '{2, 2, 2};
    else     exp_k = '{1, 2, 1};
    bus.mac_req = 8'h01;
    bus.sfu_req = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_gnt(kind);
      chk($sformatf("arb%0d", n), kind, exp_k[n]);
    end
    bus.mac_req = '0;
    bus.sfu_req = 1'b0;
    for (int i = 0; i < 6; i++)
      tick();
    chk("arb_idle", busy, 0);

    // clr_stats after four macros written
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr1_num", num_wm, 0);
    seen = '0;
    bus.mac_req = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | bus.mac_gnt;
      if (i == 3)
        bus.mac_req = '0;
      tick();
    end
    chk("four_seen", seen, 8'h0F);
    chk("four_num", num_wm, 4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr2_num", num_wm, 0);
    chk("clr2_use", usage, 0);
    bus.mac_req = 8'h04;
    tick();
    chk("co_gnt", bus.mac_gnt, 8'h04);
    clr = 1'b1;
    bus.mac_req = '0;
    tick();
    clr = 1'b0;
    chk("co_num", num_wm, 0);
    bus.mac_req = 8'h04;
    tick();
    bus.mac_req = '0;
    tick();
    chk("m2_num", num_wm, 1);

    // reset while waiting for read data
    bus.sfu_req = 1'b1;
    tick();
    chk("rw_gnt", bus.sfu_gnt, 1);
    bus.sfu_req = 1'b0;
    tick();
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    chk("rw_busy", busy, 0);
    chk("rw_raddr", bus.rs_sfu_read_addr, 0);
    chk("rw_num", num_wm, 0);
    chk("rw_web", bus.rs_web, 0);
    vflag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vflag = vflag | bus.sfu_rdata_valid;
      tick();
    end
    chk("rw_novalid", vflag, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_sram_arbiter.md
Name: result_sram_arbiter

Overview:
- Sequences access to the shared result SRAM port between NUM_REQ PIM macro write-back requesters and one SFU read requester.
- Grants one request at a time and drives the SRAM's one-hot write-enable vector, write address and SFU read address.
- Times SFU read data and keeps written-macro and memory-usage statistics.
- Sits between the macro array / SFU and the result SRAM.

Parameters:
NUM_REQ, 8, number of macro write-back requesters
ADDR_W, 32, SRAM address width
RMC_W, 16, width of rows-per-macro configuration
READ_LAT, 1, SRAM read latency in cycles from read-enable to data valid (>=1)

Ports:
clk  input  1  clock, all logic on posedge
RSTn  input  1  reset, synchronous, active-low
rmc_of_each_macro  input  RMC_W  result bytes owned by each macro
mac_req  input  NUM_REQ  per-macro write-back request, level
mac_gnt  output  NUM_REQ  one-hot, one-cycle grant pulse
sfu_req  input  1  SFU read request, level
sfu_addr  input  ADDR_W  SFU read base address, sampled at grant
sfu_gnt  output  1  one-cycle SFU grant pulse
sfu_rdata_valid  output  1  one-cycle pulse, SRAM SFU data valid
rs_web  output  NUM_REQ+1  SRAM enables; bit i = macro i write, bit NUM_REQ = SFU read
rs_write_addr  output  ADDR_W  base address of granted macro
rs_sfu_read_addr  output  ADDR_W  latched SFU read address
clr_stats  input  1  clears statistics
num_of_wm  output  32  distinct macros written since reset/clear
result_memory_usage  output  32  high-water mark of num_of_wm*rmc
busy  output  1  high when state != IDLE

Behaviour:
- Reset (RSTn=0 at posedge): all outputs 0, state IDLE, rr_ptr=0, written mask 0. An in-flight read is abandoned; no sfu_rdata_valid is issued.
- States: IDLE, WRITE, READ, WAIT.
- IDLE: arbitrate. The winner's grant is registered, so mac_gnt/sfu_gnt and the rs_web bit assert in the cycle after the request is seen.
  - Macro win -> WRITE.
  - SFU win -> READ.
  - No request -> stay IDLE.
- Round-robin: candidates are macros 0..NUM_REQ-1 plus SFU as slot NUM_REQ. Search starts at rr_ptr. After a grant, rr_ptr = winner+1, wrapping to 0 after NUM_REQ.
- WRITE (1 cycle):
  - mac_gnt[i]=1, rs_web[i]=1.
  - rs_write_addr = i*rmc_of_each_macro, computed with current rmc and truncated to ADDR_W.
  - Next state IDLE.
  - Requester must drop req in the cycle after gnt; if req is still high it counts as a new request.
- Minimum spacing between macro grants is therefore 2 cycles.
- READ (1 cycle):
  - sfu_gnt=1, rs_web[NUM_REQ]=1, rs_sfu_read_addr <= sfu_addr.
  - -> WAIT with counter = READ_LAT-1.
- WAIT: no grants. When the counter reaches 0, sfu_rdata_valid=1 for one cycle -> IDLE. With READ_LAT=1, valid pulses the cycle after READ.
- Statistics:
  - On a grant to macro i with written[i]=0: set written[i], num_of_wm+1, in the WRITE cycle.
  - In every IDLE cycle with no grant issued: if num_of_wm*rmc (32-bit truncate) > result_memory_usage, update it. The usage register never decreases except via reset or clr_stats.
  - clr_stats (single cycle) zeroes the mask, num_of_wm and result_memory_usage.
  - clr_stats coinciding with a first write: the clear wins and the write is not counted.
- rs_write_addr and rs_sfu_read_addr hold their last values when not granting.
- rs_web is zero in IDLE and WAIT.

Optional Feature:
SFU_PRIORITY_EN:
- Defined: in IDLE, sfu_req beats all macro requests. rr_ptr is not updated on SFU grants and covers macros only.
- Undefined: SFU is an ordinary round-robin slot as described above.

Test Plan:
- Reset: RSTn=0 while in WAIT -> next cycle state IDLE, all outputs 0, no sfu_rdata_valid ever follows.
- Round-robin: rmc=512, mac_req=8'hFF held, sfu_req=0 -> grants to macros 0,1,...,7,0 every 2 cycles; rs_write_addr 0,512,...,3584; num_of_wm ends at 8; result_memory_usage=4096 once a no-grant IDLE cycle occurs.
- Repeat write: macro 3 requests 3 times -> num_of_wm=1 and three one-cycle rs_web[3] pulses.
- SFU read, READ_LAT=3: sfu_req with sfu_addr=0x1000 ->
  - sfu_gnt and rs_web[8] pulse together, rs_sfu_read_addr=0x1000;
  - sfu_rdata_valid 3 cycles later;
  - no macro grants in between.
- Fairness/priority: mac_req=8'h01 and sfu_req both held ->
  - without SFU_PRIORITY_EN: grants alternate macro0, SFU, macro0;
  - with it: SFU wins every arbitration.
- clr_stats after 4 macros written -> num_of_wm=0, result_memory_usage=0; a subsequent write to macro 2 gives num_of_wm=1.
